// File: rtl/cnt163_pkg.sv
// Shared types and widths for the cnt163 interval timer.
package cnt163_pkg;

  localparam int unsigned SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    LOAD  = 2'd2,
    RUN   = 2'd3
  } state_t;

endpackage

// File: rtl/cnt163_slice.sv
// One 163-style 4-bit synchronous counter slice: sync clear, parallel load,
// count when both ENP and ENT are high; RCO forwards ENT at all-ones.
module cnt163_slice
  import cnt163_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [SLICE_W-1:0] d,
  input  logic               enp,
  input  logic               ent,
  output logic [SLICE_W-1:0] q,
  output logic               rco
);

  // Counter register: clear beats load beats count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (enp && ent) begin
      q <= q + SLICE_W'(1);
    end
  end

  assign rco = ent & (q == {SLICE_W{1'b1}});

endmodule

// File: rtl/cnt163_timer_ctrl.sv
// Programmable one-shot / periodic interval timer sequencing a cascade of
// cnt163 slices. Define CNT163_AUTORELOAD_EN to build the periodic reload
// path; without it cfg_periodic is ignored and every run is one-shot.
module cnt163_timer_ctrl
  import cnt163_pkg::*;
#(
  parameter  int unsigned SLICES = 2,
  localparam int unsigned W      = SLICE_W * SLICES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic [W-1:0] cfg_period,
  input  logic         cfg_periodic,
  input  logic         start,
  input  logic         stop,
  output logic         busy,
  output logic         tick,
  output logic [W-1:0] count
);

  state_t        state;
  state_t        state_nxt;
  logic [W-1:0]  preset_q;
  logic          periodic;
  logic          cfg_acc;
  logic          terminal;
  logic          run_en;
  logic          reload;
  logic          slice_load;
  logic [SLICES:0] ent_chain;

  assign cfg_acc = cfg_valid && ((state == IDLE) || (state == ARMED));

`ifdef CNT163_AUTORELOAD_EN
  logic periodic_q;

  // Latched run mode, captured with the preset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      periodic_q <= 1'b0;
    end else if (cfg_acc) begin
      periodic_q <= cfg_periodic;
    end
  end

  assign periodic = periodic_q;
`else
  logic unused_cfg_periodic;

  assign unused_cfg_periodic = cfg_periodic;
  assign periodic            = 1'b0;
`endif

  // Preset is the two's complement of the period so the count ends at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      preset_q <= '0;
    end else if (cfg_acc) begin
      preset_q <= W'(0) - cfg_period;
    end
  end

  // Terminal count is the ripple carry out of the top slice.
  assign ent_chain[0] = 1'b1;
  assign terminal     = ent_chain[SLICES];

  // stop suppresses reload, load and counting; one-shot holds at terminal.
  assign reload     = (state == RUN) && terminal && periodic && !stop;
  assign slice_load = ((state == LOAD) && !stop) || reload;
  assign run_en     = (state == RUN) && !stop && !terminal;

  // Counter slice cascade, slice 0 in the LSBs.
  for (genvar k = 0; k < SLICES; k++) begin : g_slice
    cnt163_slice u_slice (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (slice_load),
      .d     (preset_q[k*SLICE_W +: SLICE_W]),
      .enp   (run_en),
      .ent   (ent_chain[k]),
      .q     (count[k*SLICE_W +: SLICE_W]),
      .rco   (ent_chain[k+1])
    );
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cfg_acc) state_nxt = ARMED;
      end
      ARMED: begin
        if (stop)       state_nxt = IDLE;
        else if (start) state_nxt = LOAD;
      end
      LOAD: begin
        state_nxt = stop ? IDLE : RUN;
      end
      RUN: begin
        if (stop)                      state_nxt = IDLE;
        else if (terminal && !periodic) state_nxt = ARMED;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      cfg_ready <= 1'b1;
      tick      <= 1'b0;
    end else begin
      state     <= state_nxt;
      busy      <= (state_nxt == LOAD) || (state_nxt == RUN);
      cfg_ready <= (state_nxt == IDLE) || (state_nxt == ARMED);
      tick      <= (state == RUN) && terminal && !stop;
    end
  end

endmodule
